bus_transfer_seq: RTL

Sequencer sitting on the other end of the shared tri-state data bus: the bus-side controller that drives the one-hot output-enable and write-enable strobes of a bank of bus registers. It executes register-to-register moves and swaps. A swap uses an internal temp latch that can itself drive the bus. It also captures the last value read off the bus. It sits between instruction decode, which issues transfer requests, and the register bank.

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_transfer_seq_reg.sv | 45 ++++
 rtl/bus_transfer_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the bus-side transfer sequencer and its helpers.
//
//   Contents:
//     DEFAULT_WIDTH - default bus / register data width
//     MAX_REGS      - largest register bank the onehot() helper can address
//     MAX_IDXW      - index width matching MAX_REGS
//     state_t       - sequencer state encoding
//     onehot()      - index -> one-hot strobe vector (MAX_REGS bits; callers
//                     size-cast the result down to their own NREGS)
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_REGS      = 32;
  localparam int MAX_IDXW      = $clog2(MAX_REGS);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SW_RD,
    SW_XFER,
    SW_WB
  } state_t;

  function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_IDXW-1:0] idx);
    logic [MAX_REGS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage : bus_pkg

// File: rtl/bus_transfer_seq_reg.sv
// -----------------------------------------------------------------------------
// bus_transfer_seq_reg
//   Generic bus register: loads d when wenable is high and drives its content
//   onto a tri-state output while oenable is high, releasing the bus (Z)
//   otherwise. Used as the swap temp latch by bus_transfer_seq.
//
//   Parameters:
//     WIDTH       - data width
//     RESET_VALUE - value held after reset
//
//   Ports:
//     clk      in   clock
//     rst_n    in   synchronous active-low reset
//     wenable  in   load d at the next rising edge
//     oenable  in   drive stored value onto out_tri
//     d        in   data to load (normally the resolved bus)
//     out_tri  out  tri-state drive, Z when oenable is low
// -----------------------------------------------------------------------------
module bus_transfer_seq_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wenable,
  input  logic             oenable,
  input  logic [WIDTH-1:0] d,
  output tri   [WIDTH-1:0] out_tri
);

  logic [WIDTH-1:0] q;

  // NOTE: the stored value is reset (not left uninitialised) so that a bus
  // write-back after an aborted sequence can never put X onto the shared bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (wenable) begin
      q <= d;
    end
  end

  assign out_tri = oenable ? q : {WIDTH{1'bz}};

endmodule : bus_transfer_seq_reg

// File: rtl/bus_transfer_seq.sv
// -----------------------------------------------------------------------------
// bus_transfer_seq
//   Bus-side sequencer for a bank of tri-state bus registers. Executes
//   register-to-register moves (one transfer cycle) and swaps (three transfer
//   cycles through an internal temp latch that can itself drive the bus).
//
//   Parameters:
//     WIDTH  - bus / register data width
//     NREGS  - number of bus registers controlled
//     IDXW   - register index width
//
//   Ports:
//     clk        in   clock
//     rst_n      in   synchronous active-low reset
//     req_valid  in   transfer request valid
//     req_ready  out  request can be accepted (IDLE)
//     req_src    in   source register index
//     req_dst    in   destination register index
//     req_swap   in   0 = move src->dst, 1 = exchange src<->dst
//     bus        in   resolved value of the shared bus
//     bus_tri    out  temp latch drive onto the bus (Z except in SW_WB)
//     oe         out  one-hot output enables to the bus registers
//     we         out  one-hot write enables to the bus registers
//     done       out  one-cycle pulse when a request completes
//     err        out  one-cycle pulse when a request is rejected
//     last_data  out  last value captured from the bus
//
//   Transfer sequences:
//     move : MOVE     oe[src], we[dst]
//     swap : SW_RD    oe[src]            (tmp <= bus)
//            SW_XFER  oe[dst], we[src]   (last_data <= bus)
//            SW_WB    we[dst], bus_tri = tmp
// -----------------------------------------------------------------------------
module bus_transfer_seq
  import bus_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREGS = 8,
  parameter int IDXW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDXW-1:0]  req_src,
  input  logic [IDXW-1:0]  req_dst,
  input  logic             req_swap,
  input  logic [WIDTH-1:0] bus,
  output tri   [WIDTH-1:0] bus_tri,
  output logic [NREGS-1:0] oe,
  output logic [NREGS-1:0] we,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] last_data
);

  // With a power-of-two bank every IDXW-bit index is valid, so the range
  // check collapses to a constant and no comparator is built.
  localparam bit              IDX_POW2 = (NREGS == (1 << IDXW));
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

  state_t          state;
  logic [IDXW-1:0] src_q;
  logic [IDXW-1:0] dst_q;
  logic            src_ok;
  logic            dst_ok;
  logic [NREGS-1:0] src_oh;
  logic [NREGS-1:0] dst_oh;

  // ---------------------------------------------------------------------------
  // Request index validation
  // ---------------------------------------------------------------------------
  generate
    if (IDX_POW2) begin : g_all_valid
      assign src_ok = 1'b1;
      assign dst_ok = 1'b1;
    end else begin : g_range_check
      assign src_ok = (req_src <= LAST_IDX);
      assign dst_ok = (req_dst <= LAST_IDX);
    end
  endgenerate

  assign req_ready = (state == IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer FSM, index latches, captured data and completion pulses
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; mixing in = would make the result depend on
  // statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      last_data <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (!src_ok || !dst_ok) begin
              // Out-of-range index: report and stay put, no strobes.
              err  <= 1'b1;
              done <= 1'b1;
            end else if (req_src == req_dst) begin
              // Moving or swapping a register with itself changes nothing.
              done <= 1'b1;
            end else begin
              src_q <= req_src;
              dst_q <= req_dst;
              state <= req_swap ? SW_RD : MOVE;
            end
          end
        end
        MOVE: begin
          last_data <= bus;
          done      <= 1'b1;
          state     <= IDLE;
        end
        SW_RD: begin
          state <= SW_XFER;
        end
        SW_XFER: begin
          last_data <= bus;
          state     <= SW_WB;
        end
        SW_WB: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe decode: purely from registered state and latched indices, so the
  // strobes only change right after a clock edge and never follow req_*.
  // ---------------------------------------------------------------------------
  assign src_oh = NREGS'(onehot(MAX_IDXW'(src_q)));
  assign dst_oh = NREGS'(onehot(MAX_IDXW'(dst_q)));

  // NOTE: both outputs get a default before the case so every path assigns
  // them and no latch is inferred.
  always_comb begin
    oe = '0;
    we = '0;
    unique case (state)
      MOVE: begin
        oe = src_oh;
        we = dst_oh;
      end
      SW_RD: begin
        oe = src_oh;
      end
      SW_XFER: begin
        oe = dst_oh;
        we = src_oh;
      end
      SW_WB: begin
        // oe stays clear here: the temp latch owns the bus this cycle.
        we = dst_oh;
      end
      default: begin
        oe = '0;
        we = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Swap temp latch: captures the source value in SW_RD and drives it back
  // onto the bus in SW_WB.
  // ---------------------------------------------------------------------------
  bus_transfer_seq_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ({WIDTH{1'b0}})
  ) u_tmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .wenable (state == SW_RD),
    .oenable (state == SW_WB),
    .d       (bus),
    .out_tri (bus_tri)
  );

endmodule : bus_transfer_seq
